// File: rtl/cobra_pkg.sv
// Shared definitions for the cybercobra_hs core: instruction fields, WS codes, ALU ops, states.
package cobra_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;

    localparam int J_BIT    = 31;
    localparam int B_BIT    = 30;
    localparam int WS_HI    = 29;
    localparam int WS_LO    = 28;
    localparam int OP_HI    = 27;
    localparam int OP_LO    = 23;
    localparam int RA1_HI   = 22;
    localparam int RA1_LO   = 18;
    localparam int RA2_HI   = 17;
    localparam int RA2_LO   = 13;
    localparam int OFF_HI   = 12;
    localparam int OFF_LO   = 5;
    localparam int WA_HI    = 4;
    localparam int WA_LO    = 0;
    localparam int CONST_HI = 27;
    localparam int CONST_LO = 5;

    typedef enum logic [1:0] {
        WS_NONE  = 2'd0,
        WS_IN    = 2'd1,
        WS_CONST = 2'd2,
        WS_ALU   = 2'd3
    } ws_e;

    localparam logic [4:0] ALU_ADD  = 5'b00000;
    localparam logic [4:0] ALU_SLL  = 5'b00001;
    localparam logic [4:0] ALU_SLT  = 5'b00010;
    localparam logic [4:0] ALU_SLTU = 5'b00011;
    localparam logic [4:0] ALU_XOR  = 5'b00100;
    localparam logic [4:0] ALU_SRL  = 5'b00101;
    localparam logic [4:0] ALU_OR   = 5'b00110;
    localparam logic [4:0] ALU_AND  = 5'b00111;
    localparam logic [4:0] ALU_SUB  = 5'b01000;
    localparam logic [4:0] ALU_SRA  = 5'b01101;
    localparam logic [4:0] ALU_EQ   = 5'b11000;
    localparam logic [4:0] ALU_NE   = 5'b11001;
    localparam logic [4:0] ALU_LT   = 5'b11100;
    localparam logic [4:0] ALU_GE   = 5'b11101;
    localparam logic [4:0] ALU_LTU  = 5'b11110;
    localparam logic [4:0] ALU_GEU  = 5'b11111;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    typedef struct packed {
        logic              j;
        logic              b;
        ws_e               ws;
        logic [4:0]        aluop;
        logic [REG_AW-1:0] ra1;
        logic [REG_AW-1:0] ra2;
        logic [7:0]        offset;
        logic [REG_AW-1:0] wa;
    } instr_t;

    function automatic instr_t decode(input logic [31:0] w);
        instr_t d;
        d.j      = w[J_BIT];
        d.b      = w[B_BIT];
        d.ws     = ws_e'(w[WS_HI:WS_LO]);
        d.aluop  = w[OP_HI:OP_LO];
        d.ra1    = w[RA1_HI:RA1_LO];
        d.ra2    = w[RA2_HI:RA2_LO];
        d.offset = w[OFF_HI:OFF_LO];
        d.wa     = w[WA_HI:WA_LO];
        return d;
    endfunction

endpackage

// File: rtl/cobra_regfile.sv
// 32 x DATA_W register file, two combinational reads, one synchronous write, async clear.
// CYBERCOBRA_X0_ZERO_EN: register 0 reads as zero and ignores writes.
module cobra_regfile
    import cobra_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] ra1,
    input  logic [REG_AW-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    input  logic              we,
    input  logic [REG_AW-1:0] wa,
    input  logic [DATA_W-1:0] wd
);

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              we_eff;

`ifdef CYBERCOBRA_X0_ZERO_EN
    assign we_eff = we && (wa != '0);
    assign rd1    = (ra1 == '0) ? '0 : regs[ra1];
    assign rd2    = (ra2 == '0) ? '0 : regs[ra2];
`else
    assign we_eff = we;
    assign rd1    = regs[ra1];
    assign rd2    = regs[ra2];
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (we_eff) begin
            regs[wa] <= wd;
        end
    end

endmodule

// File: rtl/cybercobra_hs.sv
// Parametrised single-cycle programmable core with valid/ready I/O channels and a halt state.
// Optional build macro CYBERCOBRA_X0_ZERO_EN (handled inside cobra_regfile).
module cybercobra_hs
    import cobra_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int PC_W     = 8,
    parameter int OUT_ADDR = 31
) (
    input  logic              CLK,
    input  logic              rst_n,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              halted,
    output logic [PC_W-1:0]   dbg_pc
);

    localparam int              SH_W   = $clog2(DATA_W);
    localparam logic [REG_AW-1:0] OUT_WA = REG_AW'(OUT_ADDR);

    state_e            state, state_nxt;
    logic [PC_W-1:0]   pc, pc_nxt, off_ext;
    instr_t            ins;
    logic [DATA_W-1:0] rd1, rd2, alu_res, wd;
    logic [SH_W-1:0]   shamt;
    logic              alu_flag;
    logic              run, exec, we, in_stall, out_stall, out_hit, out_load, halt_op;

    assign ins       = decode(imem_rdata);
    assign imem_addr = pc;
    assign dbg_pc    = pc;

    // Stall terms: a pending IN with no data, or overwriting an unconsumed output.
    assign run       = (state == RUN);
    assign out_hit   = (ins.wa == OUT_WA) && (ins.ws != WS_NONE);
    assign out_stall = out_hit && out_valid && !out_ready;
    assign in_stall  = (ins.ws == WS_IN) && !in_valid;
    assign exec      = run && !in_stall && !out_stall;
    assign in_ready  = run && (ins.ws == WS_IN) && !out_stall;
    assign we        = exec && (ins.ws != WS_NONE);
    assign out_load  = exec && out_hit;
    assign halt_op   = ins.j && (ins.offset == '0) && (ins.ws == WS_NONE);

    cobra_regfile #(.DATA_W(DATA_W)) u_rf (
        .CLK   (CLK),
        .rst_n (rst_n),
        .ra1   (ins.ra1),
        .ra2   (ins.ra2),
        .rd1   (rd1),
        .rd2   (rd2),
        .we    (we),
        .wa    (ins.wa),
        .wd    (wd)
    );

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        shamt    = rd2[SH_W-1:0];
        case (ins.aluop)
            ALU_ADD:  alu_res = rd1 + rd2;
            ALU_SLL:  alu_res = rd1 << shamt;
            ALU_SLT:  alu_res = DATA_W'($signed(rd1) < $signed(rd2));
            ALU_SLTU: alu_res = DATA_W'(rd1 < rd2);
            ALU_XOR:  alu_res = rd1 ^ rd2;
            ALU_SRL:  alu_res = rd1 >> shamt;
            ALU_OR:   alu_res = rd1 | rd2;
            ALU_AND:  alu_res = rd1 & rd2;
            ALU_SUB:  alu_res = rd1 - rd2;
            ALU_SRA:  alu_res = $unsigned($signed(rd1) >>> shamt);
            ALU_EQ:   alu_flag = (rd1 == rd2);
            ALU_NE:   alu_flag = (rd1 != rd2);
            ALU_LT:   alu_flag = ($signed(rd1) < $signed(rd2));
            ALU_GE:   alu_flag = ($signed(rd1) >= $signed(rd2));
            ALU_LTU:  alu_flag = (rd1 < rd2);
            ALU_GEU:  alu_flag = (rd1 >= rd2);
            default:  ;
        endcase
    end

    always_comb begin
        wd = '0;
        case (ins.ws)
            WS_IN:    wd = in_data;
            WS_CONST: wd = DATA_W'($signed(imem_rdata[CONST_HI:CONST_LO]));
            WS_ALU:   wd = alu_res;
            default:  wd = '0;
        endcase
    end

    // Branch target wraps modulo 2^PC_W by construction.
    assign off_ext = PC_W'($signed(ins.offset));
    assign pc_nxt  = (ins.j || (ins.b && alu_flag)) ? pc + off_ext : pc + PC_W'(1);

    always_comb begin
        state_nxt = state;
        halted    = (state == HALT);
        if (exec && halt_op) state_nxt = HALT;
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            pc    <= '0;
        end else begin
            state <= state_nxt;
            if (exec) pc <= pc_nxt;
        end
    end

    // A same-cycle load wins over consumption so the new value stays valid.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (out_load) begin
            out_data  <= wd;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cybercobra_hs.sv
// Directed self-checking bench for cybercobra_hs with a behavioural instruction ROM.
module tb_cybercobra_hs;
    localparam int DATA_W = 32, PC_W = 8, OUT_ADDR = 31;

    logic              CLK = 1'b0;
    logic              rst_n = 1'b0;
    logic [PC_W-1:0]   imem_addr;
    logic [31:0]       imem_rdata;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic              halted;
    logic [PC_W-1:0]   dbg_pc;

    logic [31:0] imem [0:255];
    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;
    assign imem_rdata = imem[imem_addr];

    cybercobra_hs #(.DATA_W(DATA_W), .PC_W(PC_W), .OUT_ADDR(OUT_ADDR)) dut (
        .CLK(CLK), .rst_n(rst_n), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .halted(halted), .dbg_pc(dbg_pc)
    );

    localparam logic [4:0] T_OP  [10] = '{5'b01000, 5'b00001, 5'b01101, 5'b00101, 5'b00010,
                                          5'b00011, 5'b00100, 5'b00111, 5'b00110, 5'b01001};
    localparam logic [4:0] T_RA1 [10] = '{5'd1, 5'd2, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1, 5'd1};
    localparam logic [31:0] T_EXP [10] = '{32'hFFFF_FFF8, 32'h0000_00A0, 32'hFFFF_FFFF, 32'h07FF_FFFF,
                                           32'h1, 32'h0, 32'hFFFF_FFF8, 32'h5, 32'hFFFF_FFFD, 32'h0};

    function automatic logic [31:0] f_const(input logic [4:0] wa, input logic [22:0] v);
        return {2'b00, 2'd2, v, wa};
    endfunction
    function automatic logic [31:0] f_alu(input logic [4:0] op, input logic [4:0] ra1,
                                          input logic [4:0] ra2, input logic [4:0] wa);
        return {2'b00, 2'd3, op, ra1, ra2, 8'd0, wa};
    endfunction
    function automatic logic [31:0] f_in(input logic [4:0] wa);
        return {2'b00, 2'd1, 15'd0, 8'd0, wa};
    endfunction
    function automatic logic [31:0] f_jmp(input logic [7:0] off);
        return {1'b1, 1'b0, 2'd0, 15'd0, off, 5'd0};
    endfunction
    function automatic logic [31:0] f_br(input logic [4:0] op, input logic [4:0] ra1,
                                         input logic [4:0] ra2, input logic [7:0] off);
        return {1'b0, 1'b1, 2'd0, op, ra1, ra2, off, 5'd0};
    endfunction

    task automatic clear_imem();
        for (int i = 0; i < 256; i++) imem[i] = 32'h0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    task automatic restart();
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        @(negedge CLK); rst_n = 1'b0;
        @(negedge CLK); rst_n = 1'b1;
    endtask

    task automatic test_const_add();
        clear_imem();
        imem[0] = f_const(5'd1, 23'd5);
        imem[1] = f_const(5'd2, 23'h7FFFFD);
        imem[2] = f_alu(5'b00000, 5'd1, 5'd2, 5'd3);
        @(negedge CLK); rst_n = 1'b0;
        @(negedge CLK);
        total++; if (dbg_pc !== 8'd0) begin bad++; $display("FAIL rst_pc got=%0d want=0", dbg_pc); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted got=%b want=0", halted); end
        total++; if (out_valid !== 1'b0 || out_data !== 32'h0) begin bad++;
            $display("FAIL rst_out got=%b/%h want=0/0", out_valid, out_data); end
        rst_n = 1'b1;
        tick(3);
        total++; if (dbg_pc !== 8'd3) begin bad++; $display("FAIL add_pc got=%0d want=3", dbg_pc); end
        total++; if (dut.u_rf.regs[1] !== 32'd5) begin bad++; $display("FAIL x1 got=%h want=5", dut.u_rf.regs[1]); end
        total++; if (dut.u_rf.regs[2] !== 32'hFFFF_FFFD) begin bad++;
            $display("FAIL x2 got=%h want=fffffffd", dut.u_rf.regs[2]); end
        total++; if (dut.u_rf.regs[3] !== 32'd2) begin bad++; $display("FAIL x3 got=%h want=2", dut.u_rf.regs[3]); end
    endtask

    // Reset over a populated regfile; in_ready must follow the IN at address 0.
    task automatic test_reset();
        clear_imem();
        imem[0] = f_in(5'd4);
        in_valid = 1'b0;
        @(negedge CLK); rst_n = 1'b0; #1;
        total++; if (dut.u_rf.regs[3] !== 32'd0) begin bad++; $display("FAIL rst_x3 got=%h want=0", dut.u_rf.regs[3]); end
        total++; if (dbg_pc !== 8'd0) begin bad++; $display("FAIL rst_pc2 got=%0d want=0", dbg_pc); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", in_ready); end
        @(negedge CLK); rst_n = 1'b1;
    endtask

    task automatic test_in_stall();
        for (int i = 0; i < 4; i++) begin
            tick(1);
            total++; if (dbg_pc !== 8'd0 || in_ready !== 1'b1) begin bad++;
                $display("FAIL in_stall_%0d got pc=%0d rdy=%b want pc=0 rdy=1", i, dbg_pc, in_ready); end
        end
        in_data = 32'h1234; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        total++; if (dbg_pc !== 8'd1) begin bad++; $display("FAIL in_pc got=%0d want=1", dbg_pc); end
        total++; if (dut.u_rf.regs[4] !== 32'h1234) begin bad++; $display("FAIL x4 got=%h want=1234", dut.u_rf.regs[4]); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL in_ready_nop got=%b want=0", in_ready); end
    endtask

    task automatic test_out_channel();
        clear_imem();
        imem[0] = f_const(5'd31, 23'd7);
        imem[1] = f_const(5'd31, 23'd9);
        imem[2] = f_in(5'd31);
        restart();
        tick(1);
        total++; if (out_valid !== 1'b1 || out_data !== 32'd7 || dbg_pc !== 8'd1) begin bad++;
            $display("FAIL out_first got=%b/%h pc=%0d want=1/7 pc=1", out_valid, out_data, dbg_pc); end
        tick(1);
        total++; if (out_data !== 32'd7 || dbg_pc !== 8'd1) begin bad++;
            $display("FAIL out_stall got=%h pc=%0d want=7 pc=1", out_data, dbg_pc); end
        out_ready = 1'b1;
        tick(1);
        total++; if (out_valid !== 1'b1 || out_data !== 32'd9 || dbg_pc !== 8'd2) begin bad++;
            $display("FAIL out_second got=%b/%h pc=%0d want=1/9 pc=2", out_valid, out_data, dbg_pc); end
        out_ready = 1'b0; in_data = 32'h77; in_valid = 1'b1; #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL in_ready_outstall got=%b want=0", in_ready); end
        tick(1);
        total++; if (dbg_pc !== 8'd2 || out_data !== 32'd9) begin bad++;
            $display("FAIL in_outstall_hold got pc=%0d data=%h want pc=2 data=9", dbg_pc, out_data); end
        out_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL in_ready_free got=%b want=1", in_ready); end
        tick(1);
        in_valid = 1'b0;
        total++; if (dbg_pc !== 8'd3 || out_data !== 32'h77 || out_valid !== 1'b1) begin bad++;
            $display("FAIL in_to_out got pc=%0d %b/%h want pc=3 1/77", dbg_pc, out_valid, out_data); end
        tick(1);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL out_drain got=%b want=0", out_valid); end
    endtask

    task automatic test_wrap();
        clear_imem();
        imem[0]   = f_jmp(8'hFF);
        imem[255] = {1'b1, 1'b0, 2'd2, 23'h000101, 5'd5};
        restart();
        tick(1);
        total++; if (dbg_pc !== 8'd255) begin bad++; $display("FAIL wrap_back got=%0d want=255", dbg_pc); end
        tick(1);
        total++; if (dbg_pc !== 8'd0) begin bad++; $display("FAIL wrap_fwd got=%0d want=0", dbg_pc); end
        total++; if (dut.u_rf.regs[5] !== 32'h101) begin bad++;
            $display("FAIL jump_write got=%h want=101", dut.u_rf.regs[5]); end
    endtask

    task automatic test_branch();
        clear_imem();
        imem[0] = f_const(5'd1, 23'd1);
        imem[2] = f_br(5'b11001, 5'd1, 5'd1, 8'd5);
        imem[4] = f_br(5'b11000, 5'd1, 5'd1, 8'hFE);
        restart();
        tick(3);
        total++; if (dbg_pc !== 8'd3) begin bad++; $display("FAIL bne_not_taken got=%0d want=3", dbg_pc); end
        tick(2);
        total++; if (dbg_pc !== 8'd2) begin bad++; $display("FAIL beq_taken got=%0d want=2", dbg_pc); end
    endtask

    task automatic test_alu();
        clear_imem();
        imem[0] = f_const(5'd1, 23'h7FFFFD);
        imem[1] = f_const(5'd2, 23'd5);
        imem[2] = f_const(5'd15, 23'd7);
        for (int i = 0; i < 10; i++) imem[3 + i] = f_alu(T_OP[i], T_RA1[i], 5'd2, 5'(6 + i));
        restart();
        tick(13);
        for (int i = 0; i < 10; i++) begin
            total++; if (dut.u_rf.regs[6 + i] !== T_EXP[i]) begin bad++;
                $display("FAIL alu_op%b got=%h want=%h", T_OP[i], dut.u_rf.regs[6 + i], T_EXP[i]); end
        end
    endtask

    task automatic test_halt();
        clear_imem();
        imem[6] = f_jmp(8'd0);
        restart();
        tick(6);
        total++; if (dbg_pc !== 8'd6 || halted !== 1'b0) begin bad++;
            $display("FAIL pre_halt got pc=%0d h=%b want pc=6 h=0", dbg_pc, halted); end
        tick(1);
        total++; if (halted !== 1'b1 || dbg_pc !== 8'd6) begin bad++;
            $display("FAIL halt_enter got pc=%0d h=%b want pc=6 h=1", dbg_pc, halted); end
        tick(10);
        total++; if (halted !== 1'b1 || dbg_pc !== 8'd6) begin bad++;
            $display("FAIL halt_hold got pc=%0d h=%b want pc=6 h=1", dbg_pc, halted); end
        #2 rst_n = 1'b0; #1;
        total++; if (halted !== 1'b0 || dbg_pc !== 8'd0) begin bad++;
            $display("FAIL halt_async_rst got pc=%0d h=%b want pc=0 h=0", dbg_pc, halted); end
        @(negedge CLK); rst_n = 1'b1;
    endtask

    task automatic test_x0();
        logic [31:0] exp;
`ifdef CYBERCOBRA_X0_ZERO_EN
        exp = 32'h0;
`else
        exp = 32'hAA;
`endif
        clear_imem();
        imem[0] = f_const(5'd0, 23'h55);
        imem[1] = f_alu(5'b00000, 5'd0, 5'd0, 5'd1);
        restart();
        tick(2);
        total++; if (dut.u_rf.regs[1] !== exp) begin bad++;
            $display("FAIL x0_add got=%h want=%h", dut.u_rf.regs[1], exp); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_const_add();
        test_reset();
        test_in_stall();
        test_out_channel();
        test_wrap();
        test_branch();
        test_alu();
        test_halt();
        test_x0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
